// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game datapath: coordinate widths,
// screen geometry, and the collision FSM state encoding.
package flappy_pkg;

  localparam int X_W      = 9;
  localparam int Y_W      = 7;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int GAP_H    = 30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOUND,
    ST_SCAN,
    ST_HIT,
    ST_RELEASE
  } coll_state_t;

  // True when a sprite of height h whose top row is y reaches past the floor.
  // The sum is formed in Y_W+1 bits so a bird near the bottom cannot wrap.
  function automatic logic below_floor(input logic [Y_W-1:0] y, input int h);
    logic [Y_W:0] bottom;
    bottom = {1'b0, y} + (Y_W+1)'(h);
    return bottom > (Y_W+1)'(SCREEN_H);
  endfunction

endpackage

// File: rtl/pipe_hit_check.sv
// Combinational test of one pipe against the bird.
// hit    : the pipe column overlaps the bird and the bird is not fully inside the gap.
// passed : the pipe's right edge has just moved past the bird's left column.
module pipe_hit_check #(
  parameter int BIRD_X = 20,
  parameter int BIRD_W = 4,
  parameter int BIRD_H = 4,
  parameter int PIPE_W = 8,
  parameter int GAP_H  = 30
) (
  input  logic [flappy_pkg::X_W-1:0] px,
  input  logic [flappy_pkg::Y_W-1:0] py,
  input  logic [flappy_pkg::Y_W-1:0] bird_y,
  output logic                       hit,
  output logic                       passed
);
  import flappy_pkg::*;

  logic [X_W:0] px_left;
  logic [X_W:0] px_right;
  logic [Y_W:0] bird_top;
  logic [Y_W:0] bird_bot;
  logic [Y_W:0] gap_top;
  logic [Y_W:0] gap_bot;
  logic         h_overlap;
  logic         v_miss;

  // Widen by one bit before adding extents so edges near the screen limits never wrap.
  always_comb begin
    px_left   = {1'b0, px};
    px_right  = px_left + (X_W+1)'(PIPE_W - 1);
    bird_top  = {1'b0, bird_y};
    bird_bot  = bird_top + (Y_W+1)'(BIRD_H - 1);
    gap_top   = {1'b0, py};
    gap_bot   = gap_top + (Y_W+1)'(GAP_H - 1);
    h_overlap = (px_left <= (X_W+1)'(BIRD_X + BIRD_W - 1)) &&
                (px_right >= (X_W+1)'(BIRD_X));
    v_miss    = (bird_top < gap_top) || (bird_bot > gap_bot);
    hit       = h_overlap && v_miss;
    passed    = (px_left + (X_W+1)'(PIPE_W)) == (X_W+1)'(BIRD_X);
  end

endmodule

// File: rtl/collision_detector.sv
// Collision detector: on each game tick, snapshots the bird and pipe positions,
// checks the floor bound, then scans one pipe per CLOCK_50 cycle.
// collided is held from a hit until a key press followed by the next tick.
// Optional build macro SCORE_COUNTER_EN enables the cleared-pipe score counter;
// without it score is tied to zero.
module collision_detector #(
  parameter int NUM_PIPES = 3,
  parameter int BIRD_X    = 20,
  parameter int BIRD_W    = 4,
  parameter int BIRD_H    = 4,
  parameter int PIPE_W    = 8,
  parameter int GAP_H     = 30
) (
  input  logic                                 CLOCK_50,
  input  logic                                 resetn,
  input  logic                                 game_clk,
  input  logic                                 key_press,
  input  logic [flappy_pkg::Y_W-1:0]           bird_y,
  input  logic [flappy_pkg::X_W*NUM_PIPES-1:0] pipe_x,
  input  logic [flappy_pkg::Y_W*NUM_PIPES-1:0] pipe_y,
  output logic                                 collided,
  output logic [7:0]                           score,
  output logic                                 frame_done
);
  import flappy_pkg::*;

  localparam int IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

  logic [1:0]               game_sync;
  logic                     game_prev;
  logic                     game_tick;
  logic [1:0]               key_sync;
  logic                     key_prev;
  logic                     key_tick;

  coll_state_t              state;
  logic [IDX_W-1:0]         idx;
  logic [Y_W-1:0]           snap_bird_y;
  logic [X_W*NUM_PIPES-1:0] snap_pipe_x;
  logic [Y_W*NUM_PIPES-1:0] snap_pipe_y;

  logic [X_W-1:0]           cur_px;
  logic [Y_W-1:0]           cur_py;
  logic                     pipe_hit;
  logic                     pipe_passed;

  // Bring game_clk and key_press into the CLOCK_50 domain and register a one-cycle rising-edge pulse.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      game_sync <= 2'b00;
      game_prev <= 1'b0;
      game_tick <= 1'b0;
      key_sync  <= 2'b00;
      key_prev  <= 1'b0;
      key_tick  <= 1'b0;
    end else begin
      game_sync <= {game_sync[0], game_clk};
      game_prev <= game_sync[1];
      game_tick <= game_sync[1] & ~game_prev;
      key_sync  <= {key_sync[0], key_press};
      key_prev  <= key_sync[1];
      key_tick  <= key_sync[1] & ~key_prev;
    end
  end

  // Route the snapshot of the pipe currently being scanned to the shared checker.
  always_comb begin
    cur_px = snap_pipe_x[idx*X_W +: X_W];
    cur_py = snap_pipe_y[idx*Y_W +: Y_W];
  end

  pipe_hit_check #(
    .BIRD_X (BIRD_X),
    .BIRD_W (BIRD_W),
    .BIRD_H (BIRD_H),
    .PIPE_W (PIPE_W),
    .GAP_H  (GAP_H)
  ) u_pipe_hit_check (
    .px     (cur_px),
    .py     (cur_py),
    .bird_y (snap_bird_y),
    .hit    (pipe_hit),
    .passed (pipe_passed)
  );

  // Collision FSM: snapshot on tick, floor bound, per-pipe scan, latched hit, and restart handshake.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      idx        <= '0;
      collided   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (game_tick) begin
            snap_bird_y <= bird_y;
            snap_pipe_x <= pipe_x;
            snap_pipe_y <= pipe_y;
            state       <= ST_BOUND;
          end
        end
        ST_BOUND: begin
          if (below_floor(snap_bird_y, BIRD_H)) begin
            collided <= 1'b1;
            state    <= ST_HIT;
          end else begin
            idx   <= '0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (pipe_hit) begin
            collided <= 1'b1;
            state    <= ST_HIT;
          end else if (idx == IDX_W'(NUM_PIPES - 1)) begin
            frame_done <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_HIT: begin
          collided <= 1'b1;
          if (key_tick) begin
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (game_tick) begin
            collided <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SCORE_COUNTER_EN
  logic [7:0] score_q;

  // Count pipes cleared; a hit on the same pipe suppresses the increment, and the restart tick clears it.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      score_q <= 8'd0;
    end else if (state == ST_RELEASE && game_tick) begin
      score_q <= 8'd0;
    end else if (state == ST_SCAN && !pipe_hit && pipe_passed) begin
      score_q <= score_q + 8'd1;
    end
  end

  assign score = score_q;
`else
  logic unused_passed;

  assign unused_passed = pipe_passed;
  assign score         = 8'd0;
`endif

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: directed scenarios followed by
// randomized frames, compared each cycle against a behavioural game model.
module tb_collision_detector;

  localparam int NUM_PIPES = 3;
  localparam int BIRD_X    = 20;
  localparam int BIRD_W    = 4;
  localparam int BIRD_H    = 4;
  localparam int PIPE_W    = 8;
  localparam int GAP_H     = 30;
  localparam int FLOOR_Y   = 120;

`ifdef SCORE_COUNTER_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  typedef enum int {PH_RUN, PH_CRASHED, PH_ARMED} phase_t;

  logic                   CLOCK_50 = 1'b0;
  logic                   resetn;
  logic                   game_clk;
  logic                   key_press;
  logic [6:0]             bird_y;
  logic [9*NUM_PIPES-1:0] pipe_x;
  logic [7*NUM_PIPES-1:0] pipe_y;
  logic                   collided;
  logic [7:0]             score;
  logic                   frame_done;

  phase_t m_phase;
  int     m_score;
  int     s_by;
  int     s_px [NUM_PIPES];
  int     s_py [NUM_PIPES];
  int     n_checks;
  int     n_pass;

  collision_detector #(
    .NUM_PIPES (NUM_PIPES),
    .BIRD_X    (BIRD_X),
    .BIRD_W    (BIRD_W),
    .BIRD_H    (BIRD_H),
    .PIPE_W    (PIPE_W),
    .GAP_H     (GAP_H)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .game_clk   (game_clk),
    .key_press  (key_press),
    .bird_y     (bird_y),
    .pipe_x     (pipe_x),
    .pipe_y     (pipe_y),
    .collided   (collided),
    .score      (score),
    .frame_done (frame_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // The bird rectangle collides with a pipe column unless it sits wholly inside the opening.
  function automatic bit ref_hit(input int px, input int py, input int by);
    bit column_touches;
    bit inside_gap;
    column_touches = (px <= BIRD_X + BIRD_W - 1) && (px + PIPE_W - 1 >= BIRD_X);
    inside_gap     = (by >= py) && (by + BIRD_H - 1 <= py + GAP_H - 1);
    return column_touches && !inside_gap;
  endfunction

  function automatic bit ref_passed(input int px);
    return (px + PIPE_W) == BIRD_X;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input int by, input int px0, input int py0,
                               input int px1, input int py1, input int px2, input int py2);
    s_by    = by;
    s_px[0] = px0; s_py[0] = py0;
    s_px[1] = px1; s_py[1] = py1;
    s_px[2] = px2; s_py[2] = py2;
    bird_y  = 7'(by);
    for (int i = 0; i < NUM_PIPES; i++) begin
      pipe_x[9*i +: 9] = 9'(s_px[i]);
      pipe_y[7*i +: 7] = 7'(s_py[i]);
    end
  endtask

  task automatic applyRandom();
    int px [NUM_PIPES];
    int py [NUM_PIPES];
    int by;
    for (int i = 0; i < NUM_PIPES; i++) begin
      py[i] = int'($urandom_range(0, 97));
      case ($urandom_range(0, 3))
        0:       px[i] = 12;
        1:       px[i] = int'($urandom_range(13, 23));
        2:       px[i] = int'($urandom_range(0, 40));
        default: px[i] = int'($urandom_range(0, 511));
      endcase
    end
    if ($urandom_range(0, 2) == 0) by = int'($urandom_range(0, 127));
    else by = py[$urandom_range(0, 2)] + int'($urandom_range(0, 26));
    applyStimulus(by, px[0], py[0], px[1], py[1], px[2], py[2]);
  endtask

  task automatic doTick(input string tag);
    bit     bound;
    int     hit_idx;
    int     start_score;
    phase_t phase;
    int     exp_score;
    bit     exp_coll;
    bit     exp_fd;
    phase       = m_phase;
    start_score = m_score;
    bound       = (s_by + BIRD_H > FLOOR_Y);
    hit_idx     = -1;
    exp_score   = start_score;
    if (!bound) begin
      for (int j = 0; j < NUM_PIPES; j++) begin
        if (hit_idx < 0 && ref_hit(s_px[j], s_py[j], s_by)) hit_idx = j;
      end
    end
    @(negedge CLOCK_50);
    game_clk = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    for (int k = 0; k <= NUM_PIPES + 3; k++) begin
      if (phase == PH_RUN) begin
        exp_coll  = (bound && k >= 2) || (hit_idx >= 0 && k >= 3 + hit_idx);
        exp_score = start_score;
        if (!bound && SCORE_EN) begin
          for (int j = 0; j < NUM_PIPES; j++) begin
            if (ref_passed(s_px[j]) && (hit_idx < 0 || j < hit_idx) && k >= 3 + j) exp_score++;
          end
        end
        exp_fd = !bound && hit_idx < 0 && k == 2 + NUM_PIPES;
      end else if (phase == PH_CRASHED) begin
        exp_coll  = 1'b1;
        exp_score = start_score;
        exp_fd    = 1'b0;
      end else begin
        exp_coll  = (k == 0);
        exp_score = (k == 0) ? start_score : 0;
        exp_fd    = 1'b0;
      end
      checkOutput($sformatf("%s collided E+%0d", tag, k), 8'(collided), 8'(exp_coll));
      checkOutput($sformatf("%s score E+%0d", tag, k), score, 8'(exp_score));
      checkOutput($sformatf("%s frame_done E+%0d", tag, k), 8'(frame_done), 8'(exp_fd));
      @(negedge CLOCK_50);
    end
    m_score = exp_score % 256;
    if (phase == PH_RUN && (bound || hit_idx >= 0)) m_phase = PH_CRASHED;
    else if (phase == PH_ARMED) m_phase = PH_RUN;
    game_clk = 1'b0;
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic pressKey(input string tag);
    @(negedge CLOCK_50);
    key_press = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    key_press = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    checkOutput({tag, " collided"}, 8'(collided), 8'(m_phase != PH_RUN));
    checkOutput({tag, " score"}, score, 8'(m_score));
    if (m_phase == PH_CRASHED) m_phase = PH_ARMED;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    m_phase   = PH_RUN;
    m_score   = 0;
    resetn    = 1'b0;
    game_clk  = 1'b0;
    key_press = 1'b0;
    applyStimulus(50, 200, 0, 300, 0, 400, 0);
    repeat (3) @(negedge CLOCK_50);
    checkOutput("reset collided", 8'(collided), 8'd0);
    checkOutput("reset score", score, 8'd0);
    checkOutput("reset frame_done", 8'(frame_done), 8'd0);
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    $display("[TB] gap clear");
    applyStimulus(50, 18, 40, 200, 0, 300, 0);
    doTick("gap_clear");

    $display("[TB] score then no score");
    applyStimulus(50, 200, 0, 12, 40, 300, 0);
    doTick("score_x12");
    applyStimulus(50, 200, 0, 11, 40, 300, 0);
    doTick("score_x11");

    $display("[TB] key ignored while running");
    pressKey("key_idle");
    applyStimulus(50, 18, 40, 12, 40, 300, 0);
    doTick("after_idle_key");

    $display("[TB] gap hit and restart");
    applyStimulus(67, 18, 40, 200, 0, 300, 0);
    doTick("gap_hit");
    doTick("tick_in_hit");
    pressKey("restart_key");
    doTick("restart_tick");
    applyStimulus(50, 18, 40, 12, 40, 300, 0);
    doTick("post_restart");

    $display("[TB] floor bound");
    applyStimulus(117, 12, 40, 200, 0, 300, 0);
    doTick("floor");
    pressKey("floor_key");
    doTick("floor_release");

    $display("[TB] reset mid-scan");
    applyStimulus(50, 12, 40, 200, 0, 18, 100);
    @(negedge CLOCK_50);
    game_clk = 1'b1;
    repeat (6) @(negedge CLOCK_50);
    checkOutput("midscan score E+3", score, 8'(m_score + (SCORE_EN ? 1 : 0)));
    resetn = 1'b0;
    @(negedge CLOCK_50);
    checkOutput("midscan reset collided", 8'(collided), 8'd0);
    checkOutput("midscan reset score", score, 8'd0);
    checkOutput("midscan reset frame_done", 8'(frame_done), 8'd0);
    game_clk = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    resetn  = 1'b1;
    m_phase = PH_RUN;
    m_score = 0;
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("midscan after reset collided c%0d", c), 8'(collided), 8'd0);
      @(negedge CLOCK_50);
    end
    applyStimulus(50, 12, 40, 200, 0, 300, 0);
    doTick("after_midscan");

    $display("[TB] randomized frames");
    for (int r = 0; r < 30; r++) begin
      if (m_phase == PH_CRASHED) begin
        pressKey($sformatf("rnd%0d key", r));
        applyRandom();
        doTick($sformatf("rnd%0d release", r));
      end
      applyRandom();
      doTick($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
